imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses. The core is held in reset until a complete frame with a correct checksum has been loaded.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  byte-stream source has a byte
- in_data  input  8  byte from source
- in_ready  output  1  loader accepts a byte; a byte transfers on an edge where in_valid & in_ready
- imem_we  output  1  one-cycle instruction-memory write strobe
- imem_addr  output  ADDR_WIDTH  word address for the write
- imem_wdata  output  32  word to write
- core_rst  output  1  reset to the core; high until load succeeds
- done  output  1  load completed, checksum matched
- error  output  1  load aborted; sticky until rst

## Operation
- Frame format: sync byte 0xA5, then word count N as 2 bytes (low byte first), then 4·N payload bytes, then 1 checksum byte.
- Checksum: 8-bit sum (mod 256) of all payload bytes only. Sync and length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
- IDLE: every accepted byte other than 0xA5 is discarded. Accepting 0xA5 moves to LEN_LO.
- LEN_LO → LEN_HI on one accepted byte. LEN_HI → DATA on the next accepted byte.
  - Exception: if N == 0 or N > 2^ADDR_WIDTH, go to ERR instead of DATA.
- DATA:
  - Bytes are packed little-endian: byte 0 goes to [7:0], byte 3 goes to [31:24].
  - A 2-bit byte counter tracks position within the word. A 16-bit word counter starts at 0.
  - On acceptance of byte 3, the assembled word and the current word counter are registered into imem_wdata/imem_addr, and the word counter increments.
  - When the word counter reaches N, the state moves to CHECK.
- CHECK: the next accepted byte is compared against the running sum. Match goes to DONE; mismatch goes to ERR.
- DONE and ERR are terminal; only rst leaves them.
- in_ready = 1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERR.
- Outputs per state:
  - DONE: done = 1, core_rst = 0.
  - ERR: error = 1, core_rst = 1.
  - All other states: done = 0, error = 0, core_rst = 1.
- imem_addr wraps never: the N bound guarantees addresses 0..N-1 ≤ 2^ADDR_WIDTH-1.

## Timing
- All outputs are registered except in_ready, which is decoded from state.
- Reset values: in_ready = 1 (state IDLE), imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst = 1, done = 0, error = 0.
  - All counters and the checksum accumulator are 0.
- Write latency: the edge that accepts byte 3 of a word drives imem_we = 1 for exactly the following cycle, with matching imem_addr and imem_wdata. imem_we is 0 in every other cycle.
  - imem_addr/imem_wdata hold their last values when imem_we = 0.
- Back-to-back writes: full-rate input (in_valid held high) yields one imem_we pulse every 4 cycles.
- Bubbles: cycles with in_valid = 0 change nothing. Partial words and the checksum are preserved across bubbles.
- The loader never stalls: no backpressure is applied during a write cycle.
- Completion: the edge that accepts a matching checksum byte sets done = 1 and core_rst = 0 in the next cycle.
  - The last imem_we pulse always occurs no later than the cycle in which the checksum byte is accepted, so memory is complete before core_rst falls.
- Errors: the edge that accepts the offending byte (bad length high byte or bad checksum) sets error = 1 in the next cycle. in_ready falls in that same cycle.
- rst mid-operation:
  - Returns to the reset values on the next edge.
  - A partial word is discarded and no write is issued for it.
  - Words already written stay in memory.
  - A new frame reloads from address 0.
- rst has priority over a simultaneous byte transfer or write.

## Test plan
- Good frame, in_valid held high: A5 02 00 13 00 00 00 93 00 10 00 B6 → exactly 2 imem_we pulses:
  - addr 0 = 0x00000013, addr 1 = 0x00100093.
  - Then done = 1, core_rst = 0, error = 0, in_ready = 0.
- Leading garbage: 00 FF 5A followed by the frame above → garbage ignored, identical writes and done.
- Bad checksum: same frame with last byte B7 → both writes occur, then error = 1, done = 0, core_rst = 1, in_ready = 0.
- Length faults:
  - A5 00 00 → error = 1 after the third byte, no writes.
  - With ADDR_WIDTH = 10, A5 01 04 (N = 1025) → error = 1, no writes.
- Random in_valid bubbles on the good frame → same two writes, each imem_we exactly one cycle, done after the checksum byte.
- rst asserted for one cycle after payload bytes 13 00 → all outputs return to reset values, no write issued.
  - The full good frame is then replayed and writes addr 0 and 1 correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed byte stream
// (sync 0xA5, 16-bit word count, little-endian payload words, 8-bit payload sum).
// It writes each assembled word to consecutive word addresses and holds the core
// in reset until a frame with a matching checksum has been fully loaded.
// ADDR_WIDTH is expected to be 1..16 (the word counter is 16 bits wide).
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [16:0] MaxWords = 17'd1 << ADDR_WIDTH;

  state_e                  state_q;
  logic [7:0]              lenLo_q;
  logic [15:0]             len_q;
  logic [1:0]              byteCnt_q;
  logic [15:0]             wordCnt_q;
  logic [7:0]              sum_q;
  logic [23:0]             wordBuf_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    coreRst_q;
  logic                    done_q;
  logic                    error_q;

  logic                    accept;
  logic [15:0]             lenFull_d;
  logic [15:0]             wordCntInc_d;
  logic                    lenBad_d;

  assign in_ready     = (state_q != DONE) && (state_q != ERR);
  assign accept       = in_valid && in_ready;
  assign lenFull_d    = {in_data, lenLo_q};
  assign wordCntInc_d = wordCnt_q + 16'd1;
  assign lenBad_d     = (lenFull_d == 16'd0) || ({1'b0, lenFull_d} > MaxWords);

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = coreRst_q;
  assign done       = done_q;
  assign error      = error_q;

  // Frame parser: one accepted byte advances the state, packs payload, and registers writes/status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lenLo_q   <= 8'd0;
      len_q     <= 16'd0;
      byteCnt_q <= 2'd0;
      wordCnt_q <= 16'd0;
      sum_q     <= 8'd0;
      wordBuf_q <= 24'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      coreRst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (in_data == SyncByte) state_q <= LEN_LO;
          end
          LEN_LO: begin
            lenLo_q <= in_data;
            state_q <= LEN_HI;
          end
          LEN_HI: begin
            len_q <= lenFull_d;
            if (lenBad_d) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            sum_q     <= sum_q + in_data;
            byteCnt_q <= byteCnt_q + 2'd1;
            wordBuf_q <= {in_data, wordBuf_q[23:8]};
            if (byteCnt_q == 2'd3) begin
              we_q      <= 1'b1;
              addr_q    <= wordCnt_q[ADDR_WIDTH-1:0];
              wdata_q   <= {in_data, wordBuf_q};
              wordCnt_q <= wordCntInc_d;
              if (wordCntInc_d == len_q) state_q <= CHECK;
            end
          end
          CHECK: begin
            if (in_data == sum_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              coreRst_q <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives framed byte streams (directed and random, with
// optional bubbles) and compares every cycle against a frame-level reference model.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  int          checks = 0;
  int          errors = 0;

  // Frame under test and its frame-level interpretation, keyed by byte index.
  logic [7:0]  stream[$];
  logic [31:0] wData[int];
  int          wAddr[int];
  int          termIdx = -1;
  bit          termOk = 1'b0;

  // Running expectation derived from how many bytes the loader has taken since reset.
  int          accCnt = 0;
  bit          expWe = 1'b0;
  logic [31:0] expAddr = 32'd0;
  logic [31:0] expData = 32'd0;
  bit          pendRst = 1'b1;
  bit          pendAcc = 1'b0;

  logic [31:0] mem[int];
  int          weCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Interpret the whole stream as the loader should: find sync, length, words, checksum.
  function automatic void computeModel();
    int sz;
    int p;
    int n;
    int sum;
    int b;
    int c;
    sz = stream.size();
    wData.delete();
    wAddr.delete();
    termIdx = -1;
    termOk  = 1'b0;
    p = -1;
    for (int i = 0; i < sz; i++) begin
      if (stream[i] == 8'hA5) begin
        p = i;
        break;
      end
    end
    if (p < 0 || p + 2 >= sz) return;
    n = int'(stream[p+1]) + 256 * int'(stream[p+2]);
    if (n == 0 || n > (1 << AW)) begin
      termIdx = p + 2;
      return;
    end
    sum = 0;
    for (int k = 0; k < n; k++) begin
      b = p + 3 + 4 * k;
      for (int j = 0; j < 4; j++) begin
        if (b + j < sz) sum += int'(stream[b+j]);
      end
      if (b + 3 < sz) begin
        wData[b+3] = {stream[b+3], stream[b+2], stream[b+1], stream[b]};
        wAddr[b+3] = k;
      end
    end
    c = p + 3 + 4 * n;
    if (c < sz) begin
      termIdx = c;
      termOk  = (stream[c] == 8'(sum));
    end
  endfunction

  function automatic logic [31:0] memRead(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'hxxxxxxxx;
  endfunction

  // Per-cycle compare: advance the model by the previous edge, then check every output.
  always @(negedge clk) begin
    bit term;
    if (pendRst) begin
      accCnt  = 0;
      expWe   = 1'b0;
      expAddr = 32'd0;
      expData = 32'd0;
    end else if (pendAcc) begin
      if (wData.exists(accCnt)) begin
        expWe   = 1'b1;
        expAddr = 32'(wAddr[accCnt]);
        expData = wData[accCnt];
      end else begin
        expWe = 1'b0;
      end
      accCnt++;
    end else begin
      expWe = 1'b0;
    end
    term = (termIdx >= 0) && (accCnt > termIdx);
    checkOutput("cyc_in_ready", 32'(in_ready), 32'(!term));
    checkOutput("cyc_done", 32'(done), 32'(term && termOk));
    checkOutput("cyc_error", 32'(error), 32'(term && !termOk));
    checkOutput("cyc_core_rst", 32'(core_rst), 32'(!(term && termOk)));
    checkOutput("cyc_imem_we", 32'(imem_we), 32'(expWe));
    checkOutput("cyc_imem_addr", 32'(imem_addr), expAddr);
    checkOutput("cyc_imem_wdata", imem_wdata, expData);
    if (imem_we) begin
      mem[int'(imem_addr)] = imem_wdata;
      weCount++;
    end
    pendRst = rst;
    pendAcc = in_valid && in_ready && !rst;
  end

  // Offer stream[0..count-1] one byte at a time, with up to maxBubble idle cycles before each.
  task automatic applyStimulus(input int count, input int maxBubble);
    int  gap;
    int  waitCnt;
    bit  rdy;
    for (int i = 0; i < count; i++) begin
      gap = (maxBubble > 0) ? int'($urandom_range(maxBubble, 0)) : 0;
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      rdy      = 1'b0;
      waitCnt  = 0;
      while (!rdy) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #2;
        waitCnt++;
        if (!rdy && waitCnt > 100) begin
          checks++;
          errors++;
          $display("[TB] FAIL handshake_timeout byte=%0d in_ready=%0b required=1", i, in_ready);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic beginReset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    mem.delete();
    weCount = 0;
  endtask

  task automatic endReset();
    computeModel();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic settle();
    repeat (6) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setGood();
    stream = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
  endtask

  task automatic checkGoodEnd(input string tag);
    checkOutput({tag, "_we_count"}, 32'(weCount), 32'd2);
    checkOutput({tag, "_mem0"}, memRead(0), 32'h00000013);
    checkOutput({tag, "_mem1"}, memRead(1), 32'h00100093);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic checkErrEnd(input string tag, input int writes);
    checkOutput({tag, "_we_count"}, 32'(weCount), 32'(writes));
    checkOutput({tag, "_error"}, 32'(error), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int n;
    int sum;
    logic [7:0] b;

    // Reset state
    beginReset();
    setGood();
    endReset();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
    checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
    checkOutput("reset_core_rst", 32'(core_rst), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);

    // Good frame at full rate
    applyStimulus(stream.size(), 0);
    settle();
    checkGoodEnd("good");

    // Leading garbage before the same frame
    beginReset();
    setGood();
    stream.push_front(8'h5A);
    stream.push_front(8'hFF);
    stream.push_front(8'h00);
    endReset();
    applyStimulus(stream.size(), 0);
    settle();
    checkGoodEnd("garbage");

    // Bad checksum
    beginReset();
    setGood();
    stream[11] = 8'hB7;
    endReset();
    applyStimulus(stream.size(), 0);
    settle();
    checkErrEnd("badsum", 2);
    checkOutput("badsum_mem1", memRead(1), 32'h00100093);

    // Zero length
    beginReset();
    stream = {8'hA5, 8'h00, 8'h00};
    endReset();
    applyStimulus(stream.size(), 0);
    settle();
    checkErrEnd("len0", 0);

    // Length one beyond capacity
    beginReset();
    stream = {8'hA5, 8'h01, 8'h04};
    endReset();
    applyStimulus(stream.size(), 0);
    settle();
    checkErrEnd("len1025", 0);

    // Good frame with random bubbles
    for (int r = 0; r < 4; r++) begin
      beginReset();
      setGood();
      endReset();
      applyStimulus(stream.size(), 3);
      settle();
      checkGoodEnd("bubbles");
    end

    // Reset after two payload bytes, then replay
    beginReset();
    setGood();
    endReset();
    applyStimulus(5, 0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("midrst_imem_we", 32'(imem_we), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_we_count", 32'(weCount), 32'd0);
    applyStimulus(stream.size(), 0);
    settle();
    checkGoodEnd("replay");

    // Capacity boundary: exactly 1024 words
    beginReset();
    stream = {8'hA5, 8'h00, 8'h04};
    sum = 0;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom_range(255, 0));
      stream.push_back(b);
      sum += int'(b);
    end
    stream.push_back(8'(sum));
    endReset();
    applyStimulus(stream.size(), 0);
    settle();
    checkOutput("full_we_count", 32'(weCount), 32'd1024);
    checkOutput("full_mem_last", memRead(1023), {stream[4098], stream[4097], stream[4096], stream[4095]});
    checkOutput("full_done", 32'(done), 32'd1);

    // Random frames: garbage, lengths, payloads, good/bad checksums, bubbles
    for (int r = 0; r < 25; r++) begin
      beginReset();
      stream.delete();
      repeat ($urandom_range(3, 0)) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'hA5) b = 8'h00;
        stream.push_back(b);
      end
      stream.push_back(8'hA5);
      if ($urandom_range(7, 0) == 0) begin
        n = ($urandom_range(1, 0) == 0) ? 0 : 1025 + int'($urandom_range(500, 0));
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
      end else begin
        n = int'($urandom_range(8, 1));
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        sum = 0;
        for (int i = 0; i < 4 * n; i++) begin
          b = 8'($urandom_range(255, 0));
          stream.push_back(b);
          sum += int'(b);
        end
        if ($urandom_range(3, 0) == 0) sum += int'($urandom_range(255, 1));
        stream.push_back(8'(sum));
      end
      endReset();
      applyStimulus(stream.size(), int'($urandom_range(2, 0)));
      settle();
      checkOutput("rand_we_count", 32'(weCount), 32'(wData.num()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
